// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: write-pointer input, storage port,
// read-pointer output and the consumer valid/ready handshake.
interface fifo_rd_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic [ADDR_W:0]   wptr_gray;
   logic [ADDR_W-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W:0]   rptr_gray;
   logic              rempty;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_ready;
   logic [ADDR_W:0]   rd_level;

   modport slave (
      input  wptr_gray,
      input  mem_rdata,
      input  rd_ready,
      output mem_raddr,
      output rptr_gray,
      output rempty,
      output rd_valid,
      output rd_data,
      output rd_level
   );

   modport master (
      output wptr_gray,
      output mem_rdata,
      output rd_ready,
      input  mem_raddr,
      input  rptr_gray,
      input  rempty,
      input  rd_valid,
      input  rd_data,
      input  rd_level
   );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-domain controller: pointer sync, empty/level flags
// and a single output register with valid/ready handshake.
module fifo_rd_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   fifo_rd_ctrl_if.slave  bus
);

   logic [ADDR_W:0]   wq1_q, wq2_q;
   logic [ADDR_W:0]   rbin_q, rbin_d;
   logic [ADDR_W:0]   rptr_gray_q, rptr_gray_d;
   logic              rempty_q, rempty_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [ADDR_W:0]   rd_level_q, rd_level_d;
   logic              pop;

   function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
      logic [ADDR_W:0] b;
      b[ADDR_W] = g[ADDR_W];
      for (int i = ADDR_W - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign pop = !rempty_q && (!rd_valid_q || bus.rd_ready);

   // Flags are computed from the post-pop pointer so empty and level
   // never lag the word just moved into the output register.
   always_comb begin
      rbin_d      = rbin_q + {{ADDR_W{1'b0}}, pop};
      rptr_gray_d = bin2gray(rbin_d);
      rempty_d    = (rptr_gray_d == wq2_q);
      rd_level_d  = gray2bin(wq2_q) - rbin_d;
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_valid_q;
      if (pop) begin
         rd_data_d  = bus.mem_rdata;
         rd_valid_d = 1'b1;
      end else if (rd_valid_q && bus.rd_ready) begin
         rd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wq1_q       <= '0;
         wq2_q       <= '0;
         rbin_q      <= '0;
         rptr_gray_q <= '0;
         rempty_q    <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_level_q  <= '0;
      end else begin
         wq1_q       <= bus.wptr_gray;
         wq2_q       <= wq1_q;
         rbin_q      <= rbin_d;
         rptr_gray_q <= rptr_gray_d;
         rempty_q    <= rempty_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         rd_level_q  <= rd_level_d;
      end
   end

   assign bus.mem_raddr = rbin_q[ADDR_W-1:0];
   assign bus.rptr_gray = rptr_gray_q;
   assign bus.rempty    = rempty_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_level  = rd_level_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed vector table, hand sequences and a
// randomized stream scored against a word-count model.
module tb_fifo_rd_ctrl;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   fifo_rd_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   logic [7:0] mem [16];

   assign bus.mem_rdata = mem[bus.mem_raddr];

   fifo_rd_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      bit         rst_first;
      int         wcnt;
      bit         rdy;
      bit         e_empty;
      bit         e_valid;
      int         e_level;
      logic [4:0] e_rptr;
      logic [7:0] e_data;
   } vec_t;

   vec_t tv [14];

   function automatic logic [4:0] gray(input int n);
      logic [4:0] b;
      b = n[4:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // called in the low phase; pulse finishes before the next rising edge
   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   int         wcount;
   int         delivered;
   int         popped;
   int         exp_lvl;
   int         s0, s1;
   int         found;
   bit         r;
   logic [7:0] d;
   logic [7:0] q [$];

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.wptr_gray = '0;
      bus.rd_ready  = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[0] = 8'h10;
      mem[1] = 8'h11;
      mem[2] = 8'h12;

      // one word, ready high
      tv[0]  = '{1, 1, 1, 1, 0, 0, 5'd0, 8'h00};
      tv[1]  = '{0, 1, 1, 1, 0, 0, 5'd0, 8'h00};
      tv[2]  = '{0, 1, 1, 0, 0, 1, 5'd0, 8'h00};
      tv[3]  = '{0, 1, 1, 1, 1, 0, 5'd1, 8'h10};
      tv[4]  = '{0, 1, 1, 1, 0, 0, 5'd1, 8'h00};
      tv[5]  = '{0, 1, 1, 1, 0, 0, 5'd1, 8'h00};
      // three words, ready low then high
      tv[6]  = '{1, 3, 0, 1, 0, 0, 5'd0, 8'h00};
      tv[7]  = '{0, 3, 0, 1, 0, 0, 5'd0, 8'h00};
      tv[8]  = '{0, 3, 0, 0, 0, 3, 5'd0, 8'h00};
      tv[9]  = '{0, 3, 0, 0, 1, 2, 5'd1, 8'h10};
      tv[10] = '{0, 3, 0, 0, 1, 2, 5'd1, 8'h10};
      tv[11] = '{0, 3, 1, 0, 1, 1, 5'd3, 8'h11};
      tv[12] = '{0, 3, 1, 1, 1, 0, 5'd2, 8'h12};
      tv[13] = '{0, 3, 1, 1, 0, 0, 5'd2, 8'h00};

      #2;
      @(negedge clk);
      rst = 1'b0;

      chk("rst_empty", int'(bus.rempty), 1);
      chk("rst_valid", int'(bus.rd_valid), 0);
      chk("rst_level", int'(bus.rd_level), 0);
      chk("rst_rptr", int'(bus.rptr_gray), 0);

      // idle with nothing written
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("idle_empty", int'(bus.rempty), 1);
         chk("idle_valid", int'(bus.rd_valid), 0);
         chk("idle_level", int'(bus.rd_level), 0);
      end

      for (int i = 0; i < 14; i++) begin
         if (tv[i].rst_first) do_reset();
         bus.wptr_gray = gray(tv[i].wcnt);
         bus.rd_ready  = tv[i].rdy;
         @(negedge clk);
         chk($sformatf("tv%0d_empty", i), int'(bus.rempty), int'(tv[i].e_empty));
         chk($sformatf("tv%0d_valid", i), int'(bus.rd_valid), int'(tv[i].e_valid));
         chk($sformatf("tv%0d_level", i), int'(bus.rd_level), tv[i].e_level);
         chk($sformatf("tv%0d_rptr", i), int'(bus.rptr_gray), int'(tv[i].e_rptr));
         if (tv[i].e_valid)
            chk($sformatf("tv%0d_data", i), int'(bus.rd_data), int'(tv[i].e_data));
      end

      // full storage drained at one word per cycle
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = 8'(i + 8'h40);
      bus.wptr_gray = 5'h18;
      bus.rd_ready  = 1'b1;
      repeat (3) @(negedge clk);
      chk("full_empty", int'(bus.rempty), 0);
      chk("full_level", int'(bus.rd_level), 16);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk($sformatf("full_valid%0d", i), int'(bus.rd_valid), 1);
         chk($sformatf("full_data%0d", i), int'(bus.rd_data), i + 8'h40);
         chk($sformatf("full_level%0d", i), int'(bus.rd_level), 15 - i);
      end
      @(negedge clk);
      chk("full_end_valid", int'(bus.rd_valid), 0);
      chk("full_end_empty", int'(bus.rempty), 1);
      chk("full_end_rptr", int'(bus.rptr_gray), 8'h18);

      // reset while a word is held and five remain
      do_reset();
      for (int i = 0; i < 6; i++) mem[i] = 8'(i + 8'h20);
      bus.wptr_gray = gray(6);
      bus.rd_ready  = 1'b0;
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         @(negedge clk);
         if (bus.rd_valid && bus.rd_level == 5) found = 1;
      end
      chk("midrst_setup", found, 1);
      chk("midrst_held", int'(bus.rd_data), 8'h20);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", int'(bus.rd_valid), 0);
      chk("midrst_empty", int'(bus.rempty), 1);
      chk("midrst_rptr", int'(bus.rptr_gray), 0);
      chk("midrst_level", int'(bus.rd_level), 0);
      bus.wptr_gray = '0;
      #1;
      rst = 1'b0;
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("postrst_valid", int'(bus.rd_valid), 0);
         chk("postrst_empty", int'(bus.rempty), 1);
      end

      // randomized interleaved stream, 60 words wrapping the pointer
      @(negedge clk);
      do_reset();
      bus.wptr_gray = '0;
      bus.rd_ready  = 1'b0;
      wcount    = 0;
      delivered = 0;
      s0 = 0;
      s1 = 0;
      q.delete();
      for (int cyc = 0; cyc < 3000 && delivered < 60; cyc++) begin
         @(negedge clk);
         popped  = delivered + int'(bus.rd_valid);
         exp_lvl = s1 - popped;
         chk("rnd_level", int'(bus.rd_level), exp_lvl);
         chk("rnd_empty", int'(bus.rempty), int'(exp_lvl == 0));
         s1 = s0;
         s0 = wcount;
         r = ($urandom_range(0, 3) != 0);
         if (bus.rd_valid && r) begin
            if (q.size() == 0) begin
               chk("rnd_extra_word", 1, 0);
            end else begin
               chk("rnd_data", int'(bus.rd_data), int'(q.pop_front()));
            end
            delivered++;
         end
         bus.rd_ready = r;
         if (wcount < 60 && wcount - popped < 16 && $urandom_range(0, 2) != 0) begin
            d = 8'($urandom);
            mem[wcount % 16] = d;
            q.push_back(d);
            wcount++;
            bus.wptr_gray = gray(wcount);
         end
      end
      chk("rnd_delivered", delivered, 60);
      chk("rnd_leftover", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
